// File: rtl/clock_counter.sv
// Time-of-day keeper driven by timer tick pulses: 24-hour hr:min:sec with manual set,
// plus an alarm FSM (IDLE/RING/SNOOZE) that counts ring and snooze time in seconds.
module clock_counter #(
    parameter int unsigned TICKS_PER_SEC = 1000,
    parameter int unsigned RING_SEC      = 60,
    parameter int unsigned SNOOZE_SEC    = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       set_mode,
    input  logic       set_sel,
    input  logic       inc,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hr,
    input  logic [5:0] alarm_min,
    input  logic       stop,
    input  logic       snooze,
    output logic [4:0] hr,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       sec_pulse,
    output logic       alarm_ring
);

    localparam int unsigned TW = $clog2(TICKS_PER_SEC + 1);
    localparam int unsigned RW = $clog2(RING_SEC + 1);
    localparam int unsigned SW = $clog2(SNOOZE_SEC + 1);

    localparam logic [TW-1:0] TICK_LAST   = TW'(TICKS_PER_SEC - 1);
    localparam logic [RW-1:0] RING_LOAD   = RW'(RING_SEC);
    localparam logic [SW-1:0] SNOOZE_LOAD = SW'(SNOOZE_SEC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    logic [TW-1:0] tick_cnt;
    logic [RW-1:0] ring_cnt;
    logic [SW-1:0] snz_cnt;
    state_t        state;
    logic          match;

    // Matching uses the displayed time, so set-mode edits can never trigger a ring.
    assign match = sec_pulse && (sec == 6'd0) && (min == alarm_min) && (hr == alarm_hr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt  <= '0;
            hr        <= '0;
            min       <= '0;
            sec       <= '0;
            sec_pulse <= 1'b0;
        end else if (set_mode) begin
            tick_cnt  <= '0;
            sec       <= '0;
            sec_pulse <= 1'b0;
            if (inc) begin
                if (set_sel) begin
                    hr <= (hr == 5'd23) ? '0 : hr + 5'd1;
                end else begin
                    min <= (min == 6'd59) ? '0 : min + 6'd1;
                end
            end
        end else if (tick) begin
            if (tick_cnt == TICK_LAST) begin
                tick_cnt  <= '0;
                sec_pulse <= 1'b1;
                if (sec == 6'd59) begin
                    sec <= '0;
                    if (min == 6'd59) begin
                        min <= '0;
                        hr  <= (hr == 5'd23) ? '0 : hr + 5'd1;
                    end else begin
                        min <= min + 6'd1;
                    end
                end else begin
                    sec <= sec + 6'd1;
                end
            end else begin
                tick_cnt  <= tick_cnt + 1'b1;
                sec_pulse <= 1'b0;
            end
        end else begin
            sec_pulse <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ring_cnt   <= '0;
            snz_cnt    <= '0;
            alarm_ring <= 1'b0;
        end else begin
            alarm_ring <= (state == RING);
            case (state)
                IDLE: begin
                    if (alarm_en && match) begin
                        state    <= RING;
                        ring_cnt <= RING_LOAD;
                    end
                end
                RING: begin
                    if (!alarm_en || stop) begin
                        state <= IDLE;
                    end else if (snooze) begin
                        state   <= SNOOZE;
                        snz_cnt <= SNOOZE_LOAD;
                    end else if (sec_pulse) begin
                        if (ring_cnt == RW'(1)) state <= IDLE;
                        else ring_cnt <= ring_cnt - 1'b1;
                    end
                end
                SNOOZE: begin
                    if (!alarm_en || stop) begin
                        state <= IDLE;
                    end else if (sec_pulse) begin
                        if (snz_cnt == SW'(1)) begin
                            state    <= RING;
                            ring_cnt <= RING_LOAD;
                        end else begin
                            snz_cnt <= snz_cnt - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_counter.sv
// Bench for clock_counter: vector table, directed corner sequences, and random stimulus
// compared each cycle against a seconds-of-day reference model.
module tb_clock_counter;

    localparam int TPS = 2;
    localparam int RS  = 3;
    localparam int SS  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick, set_mode, set_sel, inc, alarm_en, stop, snooze;
    logic [4:0] alarm_hr;
    logic [5:0] alarm_min;
    logic [4:0] hr;
    logic [5:0] min, sec;
    logic       sec_pulse, alarm_ring;

    int checks = 0;
    int passed = 0;

    // reference model: time as seconds of day, alarm as mode + elapsed seconds
    int m_tod, m_tc, m_pulse, m_mode, m_el, m_ring;

    clock_counter #(.TICKS_PER_SEC(TPS), .RING_SEC(RS), .SNOOZE_SEC(SS)) dut (
        .clk(clk), .reset(reset), .tick(tick), .set_mode(set_mode), .set_sel(set_sel),
        .inc(inc), .alarm_en(alarm_en), .alarm_hr(alarm_hr), .alarm_min(alarm_min),
        .stop(stop), .snooze(snooze), .hr(hr), .min(min), .sec(sec),
        .sec_pulse(sec_pulse), .alarm_ring(alarm_ring)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic t, sm, sel, in;
        int   eh, em, es, ep;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_time(input string name, input int eh, input int em, input int es);
        check({name, ".hr"}, int'(hr), eh);
        check({name, ".min"}, int'(min), em);
        check({name, ".sec"}, int'(sec), es);
    endtask

    task automatic model_reset();
        m_tod = 0; m_tc = 0; m_pulse = 0; m_mode = 0; m_el = 0; m_ring = 0;
    endtask

    task automatic model_step();
        int h, m, s;
        bit match;
        h = m_tod / 3600; m = (m_tod / 60) % 60; s = m_tod % 60;
        match = (m_pulse == 1) && s == 0 && m == int'(alarm_min) && h == int'(alarm_hr);
        m_ring = (m_mode == 1);
        case (m_mode)
            0: if (alarm_en && match) begin m_mode = 1; m_el = 0; end
            1: if (!alarm_en || stop) m_mode = 0;
               else if (snooze) begin m_mode = 2; m_el = 0; end
               else if (m_pulse == 1) begin m_el++; if (m_el == RS) m_mode = 0; end
            default: if (!alarm_en || stop) m_mode = 0;
               else if (m_pulse == 1) begin m_el++; if (m_el == SS) begin m_mode = 1; m_el = 0; end end
        endcase
        if (set_mode) begin
            m_tc = 0; m_pulse = 0;
            if (inc) begin
                if (set_sel) h = (h + 1) % 24;
                else m = (m + 1) % 60;
            end
            m_tod = h * 3600 + m * 60;
        end else if (tick) begin
            if (m_tc == TPS - 1) begin
                m_tc = 0; m_pulse = 1; m_tod = (m_tod + 1) % 86400;
            end else begin
                m_tc++; m_pulse = 0;
            end
        end else begin
            m_pulse = 0;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        tick = 0; set_mode = 0; set_sel = 0; inc = 0; stop = 0; snooze = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1;
    endtask

    task automatic ticks(input int n);
        tick = 1;
        repeat (n) step();
        tick = 0;
    endtask

    task automatic ring_at_0001(input int n_ticks);
        do_reset();
        alarm_hr = 5'd0; alarm_min = 6'd1; alarm_en = 1;
        ticks(n_ticks);
    endtask

    vec_t vt[11];
    int   pulses;

    initial begin
        vt[0]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{1, 0, 0, 0, 0, 0, 1, 1};
        vt[2]  = '{0, 0, 0, 0, 0, 0, 1, 0};
        vt[3]  = '{1, 0, 0, 0, 0, 0, 1, 0};
        vt[4]  = '{1, 0, 0, 0, 0, 0, 2, 1};
        vt[5]  = '{1, 1, 0, 0, 0, 0, 0, 0};
        vt[6]  = '{0, 1, 0, 1, 0, 1, 0, 0};
        vt[7]  = '{1, 1, 1, 1, 1, 1, 0, 0};
        vt[8]  = '{0, 0, 1, 1, 1, 1, 0, 0};
        vt[9]  = '{1, 0, 0, 0, 1, 1, 0, 0};
        vt[10] = '{1, 0, 0, 0, 1, 1, 1, 1};

        alarm_en = 0; alarm_hr = 5'd0; alarm_min = 6'd0;
        do_reset();
        chk_time("reset", 0, 0, 0);
        check("reset.pulse", int'(sec_pulse), 0);
        check("reset.ring", int'(alarm_ring), 0);

        // vector table
        for (int i = 0; i < 11; i++) begin
            tick = vt[i].t; set_mode = vt[i].sm; set_sel = vt[i].sel; inc = vt[i].in;
            step();
            chk_time($sformatf("vec%0d", i), vt[i].eh, vt[i].em, vt[i].es);
            check($sformatf("vec%0d.pulse", i), int'(sec_pulse), vt[i].ep);
        end
        clear_inputs();

        // ten ticks -> five 1-cycle pulses, then hold
        do_reset();
        pulses = 0;
        tick = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            pulses += int'(sec_pulse);
        end
        tick = 0;
        check("t1.pulses", pulses, 5);
        chk_time("t1", 0, 0, 5);
        repeat (3) step();
        chk_time("t1.hold", 0, 0, 5);
        check("t1.hold.pulse", int'(sec_pulse), 0);

        // set 23:59 then run across midnight
        do_reset();
        set_mode = 1; inc = 1; set_sel = 1;
        repeat (23) step();
        set_sel = 0;
        repeat (59) step();
        inc = 0; set_mode = 0;
        step();
        chk_time("t2.set", 23, 59, 0);
        ticks(118);
        chk_time("t2.pre", 23, 59, 59);
        ticks(2);
        chk_time("t2.wrap", 0, 0, 0);
        check("t2.pulse", int'(sec_pulse), 1);

        // minute wrap in set mode has no hour carry, ticks frozen
        do_reset();
        set_mode = 1; inc = 1; set_sel = 1;
        repeat (5) step();
        set_sel = 0;
        repeat (60) step();
        inc = 0;
        chk_time("t3.wrap", 5, 0, 0);
        tick = 1;
        repeat (4) step();
        tick = 0;
        chk_time("t3.frozen", 5, 0, 0);
        check("t3.pulse", int'(sec_pulse), 0);
        set_mode = 0;

        // alarm ring latency and auto stop
        ring_at_0001(120);
        check("t4.e0", int'(alarm_ring), 0);
        step();
        check("t4.e1", int'(alarm_ring), 0);
        step();
        check("t4.e2", int'(alarm_ring), 1);
        ticks(6);
        check("t4.still", int'(alarm_ring), 1);
        repeat (2) step();
        check("t4.off", int'(alarm_ring), 0);

        // snooze, re-ring, stop+snooze
        ring_at_0001(120);
        repeat (2) step();
        snooze = 1; step(); snooze = 0; step();
        check("t5.snz", int'(alarm_ring), 0);
        ticks(4);
        repeat (2) step();
        check("t5.rering", int'(alarm_ring), 1);
        stop = 1; snooze = 1; step(); stop = 0; snooze = 0; step();
        check("t5.stop", int'(alarm_ring), 0);
        repeat (8) step();
        check("t5.idle", int'(alarm_ring), 0);

        // async reset mid-ring
        ring_at_0001(124);
        repeat (2) step();
        chk_time("t6.pre", 0, 1, 2);
        check("t6.ring", int'(alarm_ring), 1);
        #2 reset = 0;
        #1;
        check("t6.async.ring", int'(alarm_ring), 0);
        chk_time("t6.async", 0, 0, 0);
        do_reset();

        // random stimulus vs model
        alarm_en = 1; alarm_hr = 5'd0; alarm_min = 6'd1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) alarm_min = 6'($urandom_range(0, 6));
            if ($urandom_range(0, 999) == 0) alarm_min = 6'd60;
            if ($urandom_range(0, 79) == 0) set_mode = ~set_mode;
            if ($urandom_range(0, 199) == 0) alarm_en = ~alarm_en;
            tick    = ($urandom_range(0, 3) != 0);
            inc     = ($urandom_range(0, 3) == 0);
            set_sel = ($urandom_range(0, 7) == 0);
            stop    = ($urandom_range(0, 99) == 0);
            snooze  = ($urandom_range(0, 29) == 0);
            step();
            check($sformatf("rand%0d {hr,min,sec,pulse,ring}", i),
                  int'({hr, min, sec, sec_pulse, alarm_ring}),
                  (((m_tod / 3600) * 64 + (m_tod / 60) % 60) * 64 + m_tod % 60) * 4
                  + m_pulse * 2 + m_ring);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
